// File: rtl/key_debounce.sv
// Debounces a raw push-button into level/press/release strobes; outputs follow a capture edge by DEBOUNCE_CYC+2 edges, no backpressure.
// Define AUTO_REPEAT_EN to make PRESS_PULSE auto-repeat while the key stays held.
module key_debounce #(
    parameter int DEBOUNCE_CYC   = 1000000,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int REPEAT_DLY     = 25000000,
    parameter int REPEAT_PER     = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_IN,
    output logic KEY_LEVEL,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE,
    output logic BUSY
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic          REL_LVL  = (KEY_ACTIVE_LOW != 0);

    generate
        if (DEBOUNCE_CYC < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
            $error("key_debounce: DEBOUNCE_CYC must be >= 2, repeat timings >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          key_s;
    logic          pressed;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= REL_LVL;
            key_s <= REL_LVL;
        end else begin
            sync1 <= KEY_IN;
            key_s <= sync1;
        end
    end

    assign pressed = key_s ^ REL_LVL;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_phase;
    logic [RW-1:0] rep_last;

    // First interval is REPEAT_DLY, every later one REPEAT_PER.
    assign rep_last = rep_phase ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            cnt           <= '0;
            KEY_LEVEL     <= 1'b0;
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            BUSY          <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt       <= '0;
            rep_phase     <= 1'b0;
`endif
        end else begin
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                PRESS_CHK: begin
                    if (!pressed) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        BUSY        <= 1'b0;
                        KEY_LEVEL   <= 1'b1;
                        PRESS_PULSE <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_cnt     <= '0;
                        rep_phase   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_cnt == rep_last) begin
                        PRESS_PULSE <= 1'b1;
                        rep_cnt     <= '0;
                        rep_phase   <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                RELEASE_CHK: begin
                    // Bounce back to HELD keeps the repeat counter where it froze.
                    if (pressed) begin
                        state <= HELD;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        BUSY          <= 1'b0;
                        KEY_LEVEL     <= 1'b0;
                        RELEASE_PULSE <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized scoreboard bench for key_debounce against a run-length reference model.
module tb_key_debounce;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLK = 1'b0;
    logic RST;
    logic KEY_IN;
    logic KEY_LEVEL;
    logic PRESS_PULSE;
    logic RELEASE_PULSE;
    logic BUSY;

    key_debounce #(
        .DEBOUNCE_CYC  (DC),
        .KEY_ACTIVE_LOW(1),
        .REPEAT_DLY    (RD),
        .REPEAT_PER    (RP)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .KEY_IN       (KEY_IN),
        .KEY_LEVEL    (KEY_LEVEL),
        .PRESS_PULSE  (PRESS_PULSE),
        .RELEASE_PULSE(RELEASE_PULSE),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int exp_presses = 0;
    int exp_releases = 0;
    int seen_presses = 0;
    int seen_releases = 0;

    // Expected {KEY_LEVEL, PRESS_PULSE, RELEASE_PULSE, BUSY} after each clock edge
    logic [3:0] exp_q[$];

    // Reference model: KEY_IN samples, accepted level, length of the current
    // disagreement run, cycles spent steadily held since acceptance.
    logic m_s1, m_s2, m_lvl;
    int   m_run, m_rep;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_s1  = 1'b1;
        m_s2  = 1'b1;
        m_lvl = 1'b0;
        m_run = 0;
        m_rep = 0;
    endtask

    // Entered and left at a negedge; drives one sample and predicts the edge.
    task automatic step(input logic k);
        logic pr, press, rel;
        KEY_IN = k;
        @(posedge CLK);
        pr    = (m_s2 == 1'b0);
        m_s2  = m_s1;
        m_s1  = k;
        press = 1'b0;
        rel   = 1'b0;
        if (pr != m_lvl) begin
            // A change is accepted after DC+1 consecutive disagreeing edges.
            m_run++;
            if (m_run == DC + 1) begin
                m_lvl = pr;
                m_run = 0;
                m_rep = 0;
                if (pr) press = 1'b1;
                else    rel   = 1'b1;
            end
        end else begin
            if (m_run == 0 && m_lvl) begin
                m_rep++;
`ifdef AUTO_REPEAT_EN
                if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RP == 0)) press = 1'b1;
`endif
            end
            m_run = 0;
        end
        if (press) exp_presses++;
        if (rel)   exp_releases++;
        exp_q.push_back({m_lvl, press, rel, (m_run > 0)});
        @(negedge CLK);
    endtask

    task automatic reset_pulse(input int cycles);
        RST = 1'b0;
        #1;
        check("reset_async", {KEY_LEVEL, PRESS_PULSE, RELEASE_PULSE, BUSY}, 4'h0);
        repeat (cycles) @(posedge CLK);
        #1;
        check("reset_hold", {KEY_LEVEL, PRESS_PULSE, RELEASE_PULSE, BUSY}, 4'h0);
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (PRESS_PULSE)   seen_presses++;
            if (RELEASE_PULSE) seen_releases++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {KEY_LEVEL, PRESS_PULSE, RELEASE_PULSE, BUSY}, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "timeout");
    end

    initial begin
        RST    = 1'b1;
        KEY_IN = 1'b1;
        model_reset();
        #2;
        RST = 1'b0;
        #1;
        check("reset_state", {KEY_LEVEL, PRESS_PULSE, RELEASE_PULSE, BUSY}, 4'h0);
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state_clocked", {KEY_LEVEL, PRESS_PULSE, RELEASE_PULSE, BUSY}, 4'h0);
        @(negedge CLK);
        RST = 1'b1;

        repeat (50) step(1'b1);                 // idle, released
        repeat (12) step(1'b0);                 // clean press
        repeat (3)  step(1'b1);                 // short release glitch
        repeat (4)  step(1'b0);
        repeat (12) step(1'b1);                 // clean release
        repeat (5) begin                        // press bounce, never accepted
            repeat (2) step(1'b0);
            repeat (2) step(1'b1);
        end
        repeat (10) step(1'b1);
        repeat (5)  step(1'b0);                 // into PRESS_CHK, counter at 2
        reset_pulse(2);
        repeat (12) step(1'b0);                 // held through reset
        repeat (12) step(1'b1);
        repeat (45) step(1'b0);                 // long hold (auto-repeat window)
        repeat (2)  step(1'b1);                 // release glitch while held
        repeat (20) step(1'b0);
        repeat (12) step(1'b1);

        repeat (400) begin
            logic lv;
            int   len;
            lv  = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 59) == 0) reset_pulse($urandom_range(1, 3));
            repeat (len) step(lv);
        end
        repeat (12) step(1'b1);

        @(posedge CLK);
        #2;
        check("queue_drained", exp_q.size(), 0);
        check("press_count", seen_presses, exp_presses);
        check("release_count", seen_releases, exp_releases);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
